// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite responder backed by a word-addressed register memory.
// One read and one write may be outstanding at a time. The read and write
// channels run independently. Responses are OKAY in range and SLVERR
// out of range.
//
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   axi_ar*, axi_r*                 read address / read data channels
//   axi_aw*, axi_w*, axi_b*         write address / data / response channels
//   axi_arprot, axi_awprot          accepted and ignored
// All outputs come straight from flops.
module axi_lite_mem_slave #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    // read address / data
    input  logic [31:0] axi_araddr,
    output logic        axi_arready,
    input  logic        axi_arvalid,
    input  logic [2:0]  axi_arprot,
    output logic [31:0] axi_rdata,
    input  logic        axi_rready,
    output logic [1:0]  axi_rresp,
    output logic        axi_rvalid,
    // write address / data / response
    input  logic [31:0] axi_awaddr,
    output logic        axi_awready,
    input  logic        axi_awvalid,
    input  logic [2:0]  axi_awprot,
    input  logic [31:0] axi_wdata,
    output logic        axi_wready,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wvalid,
    input  logic        axi_bready,
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned IDX_W = DEPTH_LOG2;
    localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic { R_IDLE, R_RESP } r_state_e;
    typedef enum logic { W_IDLE, W_RESP } w_state_e;

    // Range check on the wrapping byte offset from BASE_ADDR.
    function automatic logic in_range(input logic [31:0] addr);
        in_range = (addr >= BASE_ADDR) && ({1'b0, addr - BASE_ADDR} < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        word_idx = IDX_W'((addr - BASE_ADDR) >> 2);
    endfunction

    logic [31:0] mem_q [DEPTH];

    // ---------------- read channel ----------------
    r_state_e    r_state_q, r_state_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    // Read state register and registered read outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Read next state.
    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (axi_arvalid) r_state_d = R_RESP;
            R_RESP:  if (axi_rready)  r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read outputs; memory is sampled at the AR edge, so a same-edge write
    // commit is not visible to this read.
    always_comb begin
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (axi_arvalid) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    if (in_range(axi_araddr)) begin
                        rdata_d = mem_q[word_idx(axi_araddr)];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end
                end
            end
            R_RESP: begin
                if (axi_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ---------------- write channel ----------------
    w_state_e    w_state_q, w_state_d;
    logic        aw_held_q, aw_held_d;
    logic        w_held_q, w_held_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;

    logic             aw_hs_c, w_hs_c, commit_c, mem_we_c;
    logic [31:0]      cmt_addr_c, cmt_data_c;
    logic [3:0]       cmt_strb_c;
    logic [IDX_W-1:0] cmt_idx_c;

    // Commit uses the latched half if held, otherwise the live handshake.
    assign aw_hs_c    = axi_awvalid & awready_q;
    assign w_hs_c     = axi_wvalid & wready_q;
    assign cmt_addr_c = aw_held_q ? awaddr_q : axi_awaddr;
    assign cmt_data_c = w_held_q  ? wdata_q  : axi_wdata;
    assign cmt_strb_c = w_held_q  ? wstrb_q  : axi_wstrb;
    assign cmt_idx_c  = word_idx(cmt_addr_c);
    assign commit_c   = (w_state_q == W_IDLE) && (aw_held_q || aw_hs_c)
                        && (w_held_q || w_hs_c);

    // Write state register, latched AW/W halves and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Write next state.
    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (commit_c)   w_state_d = W_RESP;
            W_RESP:  if (axi_bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write outputs and latches.
    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        mem_we_c  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (commit_c) begin
                    mem_we_c  = in_range(cmt_addr_c);
                    bresp_d   = in_range(cmt_addr_c) ? RESP_OKAY : RESP_SLVERR;
                    bvalid_d  = 1'b1;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end else begin
                    if (aw_hs_c) begin
                        aw_held_d = 1'b1;
                        awaddr_d  = axi_awaddr;
                        awready_d = 1'b0;
                    end
                    if (w_hs_c) begin
                        w_held_d = 1'b1;
                        wdata_d  = axi_wdata;
                        wstrb_d  = axi_wstrb;
                        wready_d = 1'b0;
                    end
                end
            end
            W_RESP: begin
                if (axi_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Byte-strobed memory write; contents are not reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (cmt_strb_c[b]) mem_q[cmt_idx_c][8*b +: 8] <= cmt_data_c[8*b +: 8];
            end
        end
    end

    logic unused_prot_c;
    assign unused_prot_c = ^{axi_arprot, axi_awprot};

    assign axi_arready = arready_q;
    assign axi_rvalid  = rvalid_q;
    assign axi_rdata   = rdata_q;
    assign axi_rresp   = rresp_q;
    assign axi_awready = awready_q;
    assign axi_wready  = wready_q;
    assign axi_bvalid  = bvalid_q;
    assign axi_bresp   = bresp_q;

endmodule

// File: doc/axi_lite_mem_slave.md
Name: axi_lite_mem_slave

Overview:
- AXI4-Lite responder backed by an internal word-addressed register memory.
- It is the counterpart of the cache's AXI4-Lite master port. It serves as the simulation and on-chip memory target for the cache and core: it accepts read and write transactions, applies byte strobes, and returns OKAY or SLVERR responses.
- At most one read and one write are outstanding at a time. The read and write channels operate independently.

Parameters:
- DEPTH_LOG2, 10, memory depth is 2**DEPTH_LOG2 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word-aligned.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rstn  in  1  asynchronous active-low reset.
- axi_araddr  in  32  read address.
- axi_arready  out  1  read address ready.
- axi_arvalid  in  1  read address valid.
- axi_arprot  in  3  ignored.
- axi_rdata  out  32  read data.
- axi_rready  in  1  read data ready.
- axi_rresp  out  2  read response.
- axi_rvalid  out  1  read data valid.
- axi_awaddr  in  32  write address.
- axi_awready  out  1  write address ready.
- axi_awvalid  in  1  write address valid.
- axi_awprot  in  3  ignored.
- axi_wdata  in  32  write data.
- axi_wready  out  1  write data ready.
- axi_wstrb  in  4  byte strobes; bit i enables byte i, i.e. wdata[8i+7:8i].
- axi_wvalid  in  1  write data valid.
- axi_bready  in  1  write response ready.
- axi_bresp  out  2  write response.
- axi_bvalid  out  1  write response valid.

Behaviour:
- Reset (rstn=0, asynchronous): arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0. Both FSMs go to IDLE and any latched address, data or strobe flags are cleared. Memory contents are not reset. A transaction in flight at reset is dropped with no response.
- Address decode: off = addr - BASE_ADDR (32-bit, wrapping). The address is in range iff addr >= BASE_ADDR and off < 4*2**DEPTH_LOG2. Word index is off[DEPTH_LOG2+1:2]; addr[1:0] is ignored.
- Read FSM, R_IDLE -> R_RESP:
  - In R_IDLE, arready=1. A handshake (arvalid&&arready) at edge N loads rdata with mem[index] and sets rresp to 2'b00 if in range, else rdata=0 and rresp=2'b10 (SLVERR).
  - rvalid=1 and arready=0 from cycle N+1. rdata and rresp are held stable while rvalid=1 && rready=0.
  - On the edge where rvalid&&rready, rvalid goes to 0 and arready to 1. The FSM returns to R_IDLE. A new AR is accepted one cycle later at the earliest, so read latency is 1 cycle and peak throughput is 1 read per 2 cycles.
- Write FSM, W_IDLE -> W_RESP:
  - In W_IDLE, awready and wready are driven independently. An AW handshake latches the address and drops awready. A W handshake latches data and strobes and drops wready. AW and W may arrive in either order, any number of cycles apart, or in the same cycle.
  - On the edge at which both are held, including the same edge as the second handshake, the write commits. Only strobed bytes of mem[index] are updated, and only if in range. bresp is 2'b00 if in range, else 2'b10.
  - bvalid=1 from the next cycle, with awready=wready=0, and is held until bvalid&&bready. On that edge bvalid goes to 0, awready and wready go to 1, and the FSM returns to W_IDLE.
  - wstrb=0 commits no bytes and still responds OKAY.
- Read/write collision: if an AR handshake and a write commit to the same word fall on the same edge, the read returns the pre-write data.
- No combinational path from any input to any output. All outputs are registered.
- AXI rules: a valid, once asserted, is never withdrawn before its ready. The block never issues a response without a preceding request.

Test Plan:
- Write 0xDEADBEEF to addr 0x10 with wstrb=4'hF (AW and W in the same cycle), then read 0x10 -> bvalid 1 cycle after commit with bresp=0; rvalid exactly 1 cycle after AR handshake with rdata=0xDEADBEEF, rresp=0.
- After the previous write, write 0x11223344 to 0x10 with wstrb=4'b0101, then read -> rdata=0xDE22BE44.
- AW at cycle 5, W at cycle 9 (addr 0x20, data 0xA5A5A5A5) -> awready low from cycle 6, write commits at the W edge, bvalid rises at cycle 10; a subsequent read of 0x20 returns 0xA5A5A5A5.
- Read with rready held low for 3 cycles after rvalid -> rvalid and rdata stable for those 3 cycles, arready=0 throughout, and arready=1 the cycle after the rready handshake.
- With DEPTH_LOG2=10, read and write addr 0x1000 (out of range) -> rresp=2'b10, rdata=0, bresp=2'b10, and mem[0] unchanged.
- Assert rstn=0 while bvalid=1 and rvalid=1 -> both valids 0 immediately (asynchronous); all readies 1 after release; no stale response is issued.
